// File: rtl/fp_add_server.sv
// fp_add_server: IEEE-754 binary32 add/subtract unit serving one request at a time, 5-cycle latency.
// Define FP_ADD_SERVER_DENORM_EN for gradual underflow; otherwise subnormals are treated/flushed as signed zero.
//
// state | meaning
// IDLE  | no result yet since reset, waiting for a Load rising edge
// ALIGN | operands captured; unpack, detect specials, align smaller significand
// ADD   | add or subtract aligned significands
// NORM  | absorb carry-out or remove leading zeros
// ROUND | round to nearest even, pack the result
// DONE  | result published on the following edge, then held until next request

module fp_add_server #(
    parameter int PRECISION = 32
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [PRECISION-1:0] A,
    input  logic [PRECISION-1:0] B,
    input  logic                 Op,
    input  logic                 Load,
    output logic [PRECISION-1:0] Result,
    output logic                 Valid,
    output logic                 Busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic                   r_load_d;
    logic [PRECISION-1:0]   r_a;
    logic [PRECISION-1:0]   r_b;
    logic                   r_op;
    logic [PRECISION-1:0]   r_result;
    logic                   r_valid;
    logic                   r_busy;

    logic [26:0]            r_big;
    logic [26:0]            r_small;
    logic [9:0]             r_exp;
    logic                   r_sign;
    logic                   r_sub;
    logic                   r_zsign;
    logic                   r_spec;
    logic [31:0]            r_spec_val;
    logic [27:0]            r_sum;
    logic [26:0]            r_norm;
    logic [9:0]             r_nexp;
    logic                   r_nzero;
    logic                   r_nflush;
    logic [31:0]            r_res;

    logic                   w_accept;
    logic                   w_sa;
    logic                   w_sb;
    logic [7:0]             w_ea;
    logic [7:0]             w_eb;
    logic [23:0]            w_siga;
    logic [23:0]            w_sigb;
    logic                   w_swap;
    logic [7:0]             w_ebig;
    logic [7:0]             w_esml;
    logic [23:0]            w_sigbig;
    logic [23:0]            w_sigsml;
    logic [7:0]             w_ediff;
    logic [4:0]             w_dsat;
    logic [26:0]            w_sml_frame;
    logic [26:0]            w_shifted;
    logic                   w_sticky;
    logic [26:0]            w_aligned;
    logic                   w_a_nan;
    logic                   w_b_nan;
    logic                   w_a_inf;
    logic                   w_b_inf;
    logic                   w_spec;
    logic [31:0]            w_spec_val;

    logic [4:0]             w_lz;
    logic [26:0]            w_norm;
    logic [9:0]             w_nexp;
    logic                   w_nzero;
    logic                   w_nflush;

    logic                   w_up;
    logic [24:0]            w_mr;
    logic [23:0]            w_mant;
    logic [9:0]             w_rexp;
    logic [31:0]            w_round_res;

    assign Result   = r_result;
    assign Valid    = r_valid;
    assign Busy     = r_busy;
    assign w_accept = Load && !r_load_d && !r_busy && (r_state == S_IDLE || r_state == S_DONE);

    // Alignment: subnormals use exponent 1; bit 0 of the 27-bit frame is sticky.
    always_comb begin
        w_sa    = r_a[31];
        w_sb    = r_b[31] ^ r_op;
        w_ea    = (r_a[30:23] == 8'd0) ? 8'd1 : r_a[30:23];
        w_eb    = (r_b[30:23] == 8'd0) ? 8'd1 : r_b[30:23];
`ifdef FP_ADD_SERVER_DENORM_EN
        w_siga  = {r_a[30:23] != 8'd0, r_a[22:0]};
        w_sigb  = {r_b[30:23] != 8'd0, r_b[22:0]};
`else
        w_siga  = (r_a[30:23] != 8'd0) ? {1'b1, r_a[22:0]} : 24'd0;
        w_sigb  = (r_b[30:23] != 8'd0) ? {1'b1, r_b[22:0]} : 24'd0;
`endif
        w_swap      = {w_eb, w_sigb} > {w_ea, w_siga};
        w_ebig      = w_swap ? w_eb : w_ea;
        w_esml      = w_swap ? w_ea : w_eb;
        w_sigbig    = w_swap ? w_sigb : w_siga;
        w_sigsml    = w_swap ? w_siga : w_sigb;
        w_ediff     = w_ebig - w_esml;
        w_dsat      = (w_ediff > 8'd26) ? 5'd26 : w_ediff[4:0];
        w_sml_frame = {w_sigsml, 3'b000};
        w_shifted   = w_sml_frame >> w_dsat;
        w_sticky    = |(w_sml_frame & ((27'd1 << w_dsat) - 27'd1));
        w_aligned   = {w_shifted[26:1], w_shifted[0] | w_sticky};

        w_a_nan    = (r_a[30:23] == 8'hFF) && (r_a[22:0] != 23'd0);
        w_b_nan    = (r_b[30:23] == 8'hFF) && (r_b[22:0] != 23'd0);
        w_a_inf    = (r_a[30:23] == 8'hFF) && (r_a[22:0] == 23'd0);
        w_b_inf    = (r_b[30:23] == 8'hFF) && (r_b[22:0] == 23'd0);
        w_spec     = w_a_nan || w_b_nan || w_a_inf || w_b_inf;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb)))
            w_spec_val = 32'h7FC0_0000;
        else if (w_a_inf)
            w_spec_val = {w_sa, 8'hFF, 23'd0};
        else
            w_spec_val = {w_sb, 8'hFF, 23'd0};
    end

    always_comb begin
        w_lz     = 5'd0;
        for (int i = 0; i < 27; i++) begin
            if (r_sum[i])
                w_lz = 5'(26 - i);
        end
        w_norm   = 27'd0;
        w_nexp   = r_exp;
        w_nzero  = 1'b0;
        w_nflush = 1'b0;
        if (r_sum[27]) begin
            w_norm = {r_sum[27:2], r_sum[1] | r_sum[0]};
            w_nexp = r_exp + 10'd1;
        end else if (r_sum == 28'd0) begin
            w_nzero = 1'b1;
        end else if ({5'd0, w_lz} >= r_exp) begin
            // Result lies below the normal range: shift only down to exponent 1.
`ifdef FP_ADD_SERVER_DENORM_EN
            w_norm = r_sum[26:0] << (r_exp[4:0] - 5'd1);
            w_nexp = 10'd1;
`else
            w_nflush = 1'b1;
`endif
        end else begin
            w_norm = r_sum[26:0] << w_lz;
            w_nexp = r_exp - {5'd0, w_lz};
        end
    end

    always_comb begin
        w_up = r_norm[2] & (r_norm[1] | r_norm[0] | r_norm[3]);
        w_mr = {1'b0, r_norm[26:3]} + {24'd0, w_up};
        if (w_mr[24]) begin
            w_mant = w_mr[24:1];
            w_rexp = r_nexp + 10'd1;
        end else begin
            w_mant = w_mr[23:0];
            w_rexp = r_nexp;
        end
        if (r_spec)
            w_round_res = r_spec_val;
        else if (r_nzero)
            w_round_res = {r_zsign, 31'd0};
        else if (r_nflush)
            w_round_res = {r_sign, 31'd0};
        else if (w_rexp >= 10'd255)
            w_round_res = {r_sign, 8'hFF, 23'd0};
        else
            w_round_res = {r_sign, (w_mant[23] ? w_rexp[7:0] : 8'd0), w_mant[22:0]};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= S_IDLE;
            r_load_d   <= 1'b1;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= 1'b0;
            r_result   <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_big      <= '0;
            r_small    <= '0;
            r_exp      <= '0;
            r_sign     <= 1'b0;
            r_sub      <= 1'b0;
            r_zsign    <= 1'b0;
            r_spec     <= 1'b0;
            r_spec_val <= '0;
            r_sum      <= '0;
            r_norm     <= '0;
            r_nexp     <= '0;
            r_nzero    <= 1'b0;
            r_nflush   <= 1'b0;
            r_res      <= '0;
        end else begin
            r_load_d <= Load;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (r_busy) begin
                        r_result <= r_res;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                    end else if (w_accept) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_op    <= Op;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    r_big      <= {w_sigbig, 3'b000};
                    r_small    <= w_aligned;
                    r_exp      <= {2'b00, w_ebig};
                    r_sign     <= w_swap ? w_sb : w_sa;
                    r_sub      <= w_sa ^ w_sb;
                    r_zsign    <= w_sa & w_sb;
                    r_spec     <= w_spec;
                    r_spec_val <= w_spec_val;
                    r_state    <= S_ADD;
                end
                S_ADD: begin
                    r_sum   <= r_sub ? ({1'b0, r_big} - {1'b0, r_small})
                                     : ({1'b0, r_big} + {1'b0, r_small});
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    r_norm   <= w_norm;
                    r_nexp   <= w_nexp;
                    r_nzero  <= w_nzero;
                    r_nflush <= w_nflush;
                    r_state  <= S_ROUND;
                end
                S_ROUND: begin
                    r_res   <= w_round_res;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_server.sv
// Scoreboard bench for fp_add_server: directed corner cases plus random operands against a real-arithmetic model.
// Follows FP_ADD_SERVER_DENORM_EN to select the expected subnormal behaviour.

module tb_fp_add_server;

`ifdef FP_ADD_SERVER_DENORM_EN
    localparam bit DENORM = 1'b1;
`else
    localparam bit DENORM = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [31:0] A;
    logic [31:0] B;
    logic        Op;
    logic        Load;
    logic [31:0] Result;
    logic        Valid;
    logic        Busy;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    int          acc_q[$];
    logic        mon_prev = 1'b0;

    fp_add_server #(.PRECISION(32)) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .A      (A),
        .B      (B),
        .Op     (Op),
        .Load   (Load),
        .Result (Result),
        .Valid  (Valid),
        .Busy   (Busy)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, want);
        end
    endtask

    // Converts a binary32 pattern to real, honouring the subnormal mode.
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        real         m;
        if (f[30:23] == 8'd0) begin
            if (!DENORM || f[22:0] == 23'd0)
                return $bitstoreal({f[31], 63'd0});
            m = real'(f[22:0]) * $bitstoreal({1'b0, 11'd874, 52'd0});
            return f[31] ? -m : m;
        end
        d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic op);
        logic [31:0] bb, r;
        logic [63:0] d, m, q, rem, half;
        real         s;
        int          e, sh;
        logic        sg, na, nb, ia, ib;
        bb = {b[31] ^ op, b[30:0]};
        na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nb = (bb[30:23] == 8'hFF) && (bb[22:0] != 23'd0);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        ib = (bb[30:23] == 8'hFF) && (bb[22:0] == 23'd0);
        if (na || nb) return 32'h7FC0_0000;
        if (ia && ib) return (a[31] == bb[31]) ? a : 32'h7FC0_0000;
        if (ia) return a;
        if (ib) return bb;
        s = f2r(a) + f2r(bb);
        if (s == 0.0) return {a[31] & bb[31], 31'd0};
        d  = $realtobits(s);
        sg = d[63];
        e  = int'(d[62:52]) - 1023;
        m  = {11'd0, 1'b1, d[51:0]};
        sh = (e >= -126) ? 29 : 29 + (-126 - e);
        if (sh > 60) begin
            q = 64'd0;
        end else begin
            q    = m >> sh;
            rem  = m & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        end
        if (e >= -126) begin
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e = e + 1;
            end
            if (e > 127) return {sg, 8'hFF, 23'd0};
            r = {sg, 8'(e + 127), q[22:0]};
        end else begin
            r = {sg, q[30:0]};
        end
        if (!DENORM && r[30:23] == 8'd0) r = {sg, 31'd0};
        return r;
    endfunction

    function automatic logic [31:0] gen_op(input logic [31:0] other, input bit rel);
        logic [31:0] sp [9] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                32'h7FC0_0001, 32'h0040_0000, 32'h807F_FFFF, 32'h7F7F_FFFF,
                                32'h0080_0000};
        logic [31:0] v;
        int          k, e;
        v = $urandom;
        k = $urandom_range(0, 15);
        if (k == 0) begin
            v = sp[$urandom_range(0, 8)];
        end else if (k <= 2) begin
            v[30:23] = 8'd0;
        end else if (rel && k <= 9) begin
            e = int'(other[30:23]) + int'($urandom_range(0, 6)) - 3;
            if (e < 1) e = 1;
            if (e > 254) e = 254;
            v[30:23] = 8'(e);
        end else if (rel && k == 10) begin
            v[30:0] = other[30:0];
        end else if (v[30:23] == 8'hFF) begin
            v[30:23] = 8'hFE;
        end
        return v;
    endfunction

    // Monitor: every rising Valid retires the oldest outstanding request.
    always @(posedge Clk) begin
        logic [31:0] e;
        int          c;
        #1;
        if (Valid === 1'b1 && mon_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got Result %08h expected no Valid", Result);
            end else begin
                e = exp_q.pop_front();
                c = acc_q.pop_front();
                check("result", Result, e);
                check("latency", 32'(cyc - c), 32'd5);
                check("busy_at_valid", {31'd0, Busy}, 32'd0);
            end
        end
        mon_prev = Valid;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op,
                         input logic [31:0] want, input bit track);
        A    = a;
        B    = b;
        Op   = op;
        Load = 1'b1;
        @(posedge Clk);
        #1;
        if (track) begin
            exp_q.push_back(want);
            acc_q.push_back(cyc);
        end
        Load = 1'b0;
        A    = $urandom;
        B    = $urandom;
        Op   = 1'($urandom_range(0, 1));
        check("busy_valid_after_accept", {30'd0, Busy, Valid}, 32'd2);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(Valid === 1'b1 && Busy === 1'b0) && n < 20) begin
            @(posedge Clk);
            #1;
            n++;
        end
        n_vec++;
        if (n >= 20) begin
            n_err++;
            $display("FAIL wait_done: timeout with Valid=%b Busy=%b, expected Valid=1 Busy=0", Valid, Busy);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ta, tb_v;
        logic        top;
        logic [31:0] dir_a   [6] = '{32'h3F80_0000, 32'h7F80_0000, 32'h7F7F_FFFF, 32'h3F80_0000,
                                     32'h0080_0000, 32'h8000_0000};
        logic [31:0] dir_b   [6] = '{32'h3F80_0000, 32'h7F80_0000, 32'h7F7F_FFFF, 32'h3380_0000,
                                     32'h0040_0000, 32'h8000_0000};
        logic        dir_op  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] dir_exp [6];
        dir_exp = '{32'h0000_0000, 32'h7FC0_0000, 32'h7F80_0000, 32'h3F80_0000,
                    (DENORM ? 32'h0040_0000 : 32'h0080_0000), 32'h8000_0000};

        Reset_n = 1'b0;
        Load    = 1'b1;
        A       = 32'd0;
        B       = 32'd0;
        Op      = 1'b0;
        #2;
        check("reset_result", Result, 32'd0);
        check("reset_valid_busy", {30'd0, Valid, Busy}, 32'd0);
        #21 Reset_n = 1'b1;

        // Load held high through reset release must not count as a rising edge.
        repeat (3) @(posedge Clk);
        #1;
        check("held_load_no_accept", {30'd0, Valid, Busy}, 32'd0);
        Load = 1'b0;
        @(posedge Clk);
        #1;

        issue(32'h3FC0_0000, 32'h3FC0_0000, 1'b0, 32'h4040_0000, 1'b1);
        wait_done();
        repeat (3) @(posedge Clk);
        #1;
        check("hold_result", Result, 32'h4040_0000);
        check("hold_valid", {31'd0, Valid}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            issue(dir_a[i], dir_b[i], dir_op[i], dir_exp[i], 1'b1);
            wait_done();
        end

        // A second Load rising edge two cycles after acceptance is dropped.
        issue(32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b1);
        @(posedge Clk);
        #1;
        A    = 32'h4120_0000;
        B    = 32'h4120_0000;
        Load = 1'b1;
        @(posedge Clk);
        #1;
        Load = 1'b0;
        wait_done();
        repeat (8) @(posedge Clk);
        #1;
        check("ignored_load_result", Result, 32'h4040_0000);
        check("ignored_load_flags", {30'd0, Valid, Busy}, 32'd2);

        // Reset in the middle of an operation aborts it.
        issue(32'h40A0_0000, 32'h3F80_0000, 1'b1, 32'h4080_0000, 1'b0);
        @(posedge Clk);
        #3;
        Reset_n = 1'b0;
        #1;
        check("abort_result", Result, 32'd0);
        check("abort_valid_busy", {30'd0, Valid, Busy}, 32'd0);
        #3 Reset_n = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        check("abort_no_valid", {30'd0, Valid, Busy}, 32'd0);

        for (int i = 0; i < 300; i++) begin
            ta   = gen_op(32'd0, 1'b0);
            tb_v = gen_op(ta, 1'b1);
            top  = 1'($urandom_range(0, 1));
            issue(ta, tb_v, top, ref_add(ta, tb_v, top), 1'b1);
            wait_done();
        end

        repeat (2) @(posedge Clk);
        #1;
        check("outstanding_requests", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_add_server.md
FP_ADD_SERVER -- requirements
Module: fp_add_server

Interface
REQ-001 SHALL have parameter PRECISION, default 32, operand/result width; only 32 (IEEE-754 binary32) is legal.
REQ-002 SHALL have port Clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port A  input  PRECISION  first operand.
REQ-005 SHALL have port B  input  PRECISION  second operand.
REQ-006 SHALL have port Op  input  1  0 = A+B, 1 = A-B.
REQ-007 SHALL have port Load  input  1  request strobe from the requesting unit (divider).
REQ-008 SHALL have port Result  output  PRECISION  packed sum/difference.
REQ-009 SHALL have port Valid  output  1  Result holds the answer to the last accepted request.
REQ-010 SHALL have port Busy  output  1  request in flight.

Function
REQ-011 SHALL accept a request on a Clk edge where Load=1, Load was 0 on the previous edge, and state is IDLE or DONE.
REQ-012 SHALL capture A, B and Op at acceptance; later input changes SHALL NOT affect that operation.
REQ-013 SHALL drive Valid=0 and Busy=1 from the cycle after acceptance.
REQ-014 SHALL ignore Load rising edges while Busy=1; no queueing.
REQ-015 SHALL step states IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE, one state per cycle.
REQ-016 SHALL assert Valid=1 and Busy=0 exactly 5 cycles after the acceptance edge.
REQ-017 SHALL hold Result and Valid in DONE until the next accepted request or reset.
REQ-018 ALIGN SHALL right-shift the smaller-exponent significand by the exponent difference, saturating at 26, keeping guard, round and sticky bits.
REQ-019 ADD SHALL add or subtract significands according to the effective sign (operand signs XOR Op).
REQ-020 NORM SHALL remove leading zeros or absorb a carry-out, adjusting the exponent.
REQ-021 ROUND SHALL round to nearest, ties to even; a carry from rounding SHALL renormalize.
REQ-022 Exact cancellation SHALL give +0 (0x00000000); (-0)+(-0) SHALL give -0.
REQ-023 Exponent overflow SHALL give signed infinity.
REQ-024 Any NaN input, or inf-inf with effective subtraction, SHALL give 0x7FC00000.
REQ-025 Inf combined with any finite operand SHALL give that infinity with its sign.

Reset
REQ-026 Reset_n=0 SHALL immediately force state IDLE, Result=0, Valid=0 and Busy=0, independent of Clk.
REQ-027 Reset during an operation SHALL abort it; no Valid pulse SHALL follow for that request.
REQ-028 After Reset_n rises, the first Load edge seen SHALL be treated as a rising edge only if Load was sampled 0 on a post-reset edge.

Configuration
REQ-029 Macro FP_ADD_SERVER_DENORM_EN defined: subnormal inputs and results SHALL be handled with gradual underflow, bit-exact to IEEE-754.
REQ-030 FP_ADD_SERVER_DENORM_EN undefined: subnormal inputs SHALL be treated as signed zero, and subnormal results SHALL flush to signed zero.
REQ-031 Latency SHALL be 5 cycles in both configurations.

Verification
REQ-032 A=0x3FC00000, B=0x3FC00000, Op=0, Load pulse -> Valid rises 5 cycles later, Result=0x40400000, Busy low.
REQ-033 A=0x3F800000, B=0x3F800000, Op=1 -> Result=0x00000000; A=0x7F800000, B=0x7F800000, Op=1 -> 0x7FC00000.
REQ-034 A=0x7F7FFFFF, B=0x7F7FFFFF, Op=0 -> Result=0x7F800000; A=0x3F800000, B=0x33800000, Op=0 (tie) -> 0x3F800000.
REQ-035 A=0x00800000, B=0x00400000, Op=1 -> 0x00400000 with the macro defined, 0x00800000 without.
REQ-036 Second Load edge 2 cycles after acceptance -> ignored; Reset_n low at cycle 2 of an operation -> Result=0 and Valid=0 at once, and no Valid afterward.
